regfile_multi: RTL

- Parametrised general-register file for the execute stage, generalised in data width, register count and flag width.
- Provides two registered read ports with optional same-cycle write bypass, a dedicated PC slot, and a flags register.
- Adds a register-list walker (LDM/STM style) that streams the registers selected by a mask, in ascending index order, over a valid/ready handshake.

---
 rtl/regfile_multi.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/regfile_multi.sv
// regfile_multi: general-register file for the execute stage, with a
// register-list walker for LDM/STM-style block transfers.
//
// Ports
//   clock, reset_n              rising-edge clock, async active-low reset
//   in_enable, sel_in, in_reg   general register write (also gates flags write)
//   flags_in                    flags write data
//   pc_in                       next PC, written to PC_IDX every cycle
//   sel_p0/sel_p1 -> p0/p1      registered read ports (latency 1)
//   pc_out, flags_out           registered copies of PC and flags
//   list_start, list_mask       launch a walk over the selected registers
//   list_ready / list_valid     element handshake
//   list_sel, list_data         current element index and live value
//   list_busy, list_done        walker active / end-of-walk pulse
//
// Walker states
//   state | meaning
//   IDLE  | waiting for list_start
//   WALK  | presenting lowest set bit of remaining mask
//   FIN   | one-cycle list_done, then back to IDLE
module regfile_multi #(
    parameter int DATA_W = 32,
    parameter int NREG   = 16,
    parameter int SEL_W  = 4,
    parameter int FLAG_W = 4,
    parameter int PC_IDX = 15,
    parameter int BYPASS = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_enable,
    input  logic [SEL_W-1:0]  sel_in,
    input  logic [DATA_W-1:0] in_reg,
    input  logic [FLAG_W-1:0] flags_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [SEL_W-1:0]  sel_p0,
    input  logic [SEL_W-1:0]  sel_p1,
    output logic [DATA_W-1:0] p0,
    output logic [DATA_W-1:0] p1,
    output logic [DATA_W-1:0] pc_out,
    output logic [FLAG_W-1:0] flags_out,
    input  logic              list_start,
    input  logic [NREG-1:0]   list_mask,
    input  logic              list_ready,
    output logic              list_valid,
    output logic [SEL_W-1:0]  list_sel,
    output logic [DATA_W-1:0] list_data,
    output logic              list_busy,
    output logic              list_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WALK = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    logic [DATA_W-1:0] regs_q  [NREG];
    logic [DATA_W-1:0] regs_d  [NREG];
    // Values visible to readers: post-write when bypassing, else pre-write.
    logic [DATA_W-1:0] rd_view [NREG];

    logic [FLAG_W-1:0] flags_q, flags_d;
    logic [FLAG_W-1:0] flags_view;
    logic [DATA_W-1:0] p0_q, p0_d;
    logic [DATA_W-1:0] p1_q, p1_d;
    logic [DATA_W-1:0] pc_out_q, pc_out_d;
    logic [FLAG_W-1:0] flags_out_q, flags_out_d;

    logic [1:0]        state_q, state_d;
    logic [NREG-1:0]   mask_q, mask_d;
    logic [SEL_W-1:0]  walk_idx;

    // Register write path: PC update first so a general write to PC_IDX wins.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
        end
        regs_d[PC_IDX] = pc_in;
        if (in_enable && (int'(sel_in) < NREG)) begin
            regs_d[sel_in] = in_reg;
        end
        flags_d = in_enable ? flags_in : flags_q;

        for (int i = 0; i < NREG; i++) begin
            rd_view[i] = (BYPASS != 0) ? regs_d[i] : regs_q[i];
        end
        flags_view = (BYPASS != 0) ? flags_d : flags_q;
    end

    always_comb begin
        p0_d        = (int'(sel_p0) < NREG) ? rd_view[sel_p0] : '0;
        p1_d        = (int'(sel_p1) < NREG) ? rd_view[sel_p1] : '0;
        pc_out_d    = rd_view[PC_IDX];
        flags_out_d = flags_view;
    end

    // Lowest set bit of the remaining mask; descending scan leaves the lowest.
    always_comb begin
        walk_idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                walk_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        case (state_q)
            ST_IDLE: begin
                if (list_start) begin
                    mask_d  = list_mask;
                    state_d = (list_mask != '0) ? ST_WALK : ST_FIN;
                end
            end
            ST_WALK: begin
                if (list_ready) begin
                    mask_d = mask_q & ~(NREG'(1) << walk_idx);
                    if (mask_d == '0) begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                mask_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            flags_q     <= '0;
            p0_q        <= '0;
            p1_q        <= '0;
            pc_out_q    <= '0;
            flags_out_q <= '0;
            state_q     <= ST_IDLE;
            mask_q      <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            flags_q     <= flags_d;
            p0_q        <= p0_d;
            p1_q        <= p1_d;
            pc_out_q    <= pc_out_d;
            flags_out_q <= flags_out_d;
            state_q     <= state_d;
            mask_q      <= mask_d;
        end
    end

    assign p0        = p0_q;
    assign p1        = p1_q;
    assign pc_out    = pc_out_q;
    assign flags_out = flags_out_q;

    // Element data is live: it follows writes to the presented register.
    assign list_valid = (state_q == ST_WALK);
    assign list_busy  = (state_q != ST_IDLE);
    assign list_done  = (state_q == ST_FIN);
    assign list_sel   = list_valid ? walk_idx : '0;
    assign list_data  = list_valid ? rd_view[walk_idx] : '0;

endmodule
